instr_fetch_stage: RTL
======================

# instr_fetch_stage

Program-counter and IF/ID pipeline-register stage directly upstream of the instruction memory. Every cycle it drives a word address to the combinational instruction memory, captures the returned instruction together with its PC into the IF/ID register, and advances the PC. It supports stall from decode, redirect (branch/jump) from execute with flush, and a sticky fault for fetches beyond the memory depth.

## Interface
- IMEM_DEPTH, 100, number of 32-bit words in instruction memory; valid word addresses are 0..IMEM_DEPTH-1.
- RESET_PC, 0, word address loaded into PC on reset; must be < IMEM_DEPTH.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on a bubble.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and IF/ID (decode cannot accept).
- redirect  in  1  branch/jump taken; load redirect_pc, flush IF/ID.
- redirect_pc  in  32  word-address target of redirect.
- imem_addr  out  32  word address to instruction memory; equals PC combinationally.
- imem_instr  in  32  instruction returned by memory in the same cycle.
- if_id_instr  out  32  registered instruction to decode.
- if_id_pc  out  32  registered word address of if_id_instr.
- if_id_valid  out  1  if_id_instr is a real instruction (0 = bubble).
- fetch_fault  out  1  sticky: a fetch was attempted at PC >= IMEM_DEPTH.

## Operation
- PC is a 32-bit word counter (not byte address); increment is +1.
- imem_addr = pc at all times, no register between them.
- Per rising edge, priority redirect > fault > stall > normal:
  - redirect=1: pc <= redirect_pc; if_id_instr <= NOP_INSTR; if_id_pc <= 0; if_id_valid <= 0. Applies even when stall=1.
  - else pc >= IMEM_DEPTH: pc holds; IF/ID loaded as bubble (valid 0, NOP_INSTR); fetch_fault <= 1.
  - else stall=1: pc, if_id_instr, if_id_pc, if_id_valid all hold.
  - else normal: if_id_instr <= imem_instr; if_id_pc <= pc; if_id_valid <= 1; pc <= pc+1.
- PC increment past IMEM_DEPTH-1 is not wrapped: pc becomes IMEM_DEPTH and the fault rule applies next cycle.
- fetch_fault stays 1 until rst; only a redirect to a valid address resumes fetch (fault flag still held).
- redirect_pc is loaded unchecked; if out of range the fault rule applies on the following edge.
- 32-bit arithmetic, pc+1 at 32'hFFFF_FFFF wraps to 0 (unreachable in practice; fault triggers earlier).

## Timing
- Reset (async, immediate on rst rise): pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_valid=0, fetch_fault=0; imem_addr=RESET_PC combinationally.
- rst asserted mid-operation discards PC and IF/ID contents immediately; no partial update on the edge where rst is high.
- First edge after rst deasserts: IF/ID captures mem[RESET_PC], valid=1; pc=RESET_PC+1.
- Fetch latency: instruction at address A appears on if_id_instr one edge after pc==A with no stall.
- Redirect penalty: redirect asserted in cycle N -> bubble in IF/ID after edge N; target instruction valid in IF/ID after edge N+1.
- Stall is level-sensitive with zero-cycle effect: the edge where stall=1 performs no update; release resumes with the held PC (no instruction lost or duplicated).
- Throughput: one instruction per cycle with stall=0 and redirect=0.

## Test plan
- Reset then run 7 cycles with memory preloaded at words 0..6 -> if_id_pc 0,1,..,6 in order, if_id_instr equals each word, if_id_valid=1 from first edge; imem_addr=7 after 7th edge.
- Stall for 3 cycles while if_id_pc=2 -> if_id_pc/instr hold at 2, imem_addr holds 3; after release next if_id_pc=3, no duplicate or skip.
- Redirect to 5 while pc=3 -> next edge if_id_valid=0, instr=NOP_INSTR, pc=5; following edge if_id_pc=5 valid=1.
- Redirect and stall same cycle, target 1 -> redirect wins: bubble in IF/ID, pc=1; with stall still high, state holds thereafter.
- Run sequentially to pc=99 then one more edge -> if_id_pc=99 valid; next edge fetch_fault=1, if_id_valid=0, pc stays 100; redirect to 0 resumes fetch with fetch_fault still 1.
- Assert rst asynchronously between edges mid-stream -> all outputs reach reset values before the next edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC register and IF/ID pipeline register feeding a combinational instruction memory
//   clk, rst          : clock, asynchronous active-high reset
//   stall             : hold PC and IF/ID for this edge
//   redirect          : load redirect_pc into PC and flush IF/ID (beats stall)
//   redirect_pc[31:0] : word-address redirect target, loaded unchecked
//   imem_addr[31:0]   : word address to memory, always equal to the PC
//   imem_instr[31:0]  : instruction returned by memory in the same cycle
//   if_id_instr/pc    : registered instruction and its word address
//   if_id_valid       : 0 marks a bubble
//   fetch_fault       : sticky until rst, set by a fetch attempt at PC >= IMEM_DEPTH
module instr_fetch_stage #(
    parameter int          IMEM_DEPTH = 100,
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        fetch_fault
);
    localparam logic [31:0] DEPTH = 32'(IMEM_DEPTH);

    logic [31:0] pc, pc_d, instr_d, ipc_d;
    logic        valid_d, fault_d, oob, bubble, load;

    assign imem_addr = pc;
    assign oob       = pc >= DEPTH;
    // a redirect or an out-of-range fetch both leave a bubble in IF/ID
    assign bubble    = redirect | oob;
    assign load      = !bubble && !stall;

    always_comb begin
        pc_d    = redirect ? redirect_pc : load ? pc + 32'd1 : pc;
        instr_d = bubble ? NOP_INSTR : load ? imem_instr : if_id_instr;
        ipc_d   = redirect ? 32'd0 : load ? pc : if_id_pc;
        valid_d = bubble ? 1'b0 : load ? 1'b1 : if_id_valid;
        fault_d = fetch_fault | (!redirect && oob);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            if_id_instr <= NOP_INSTR;
            if_id_pc    <= 32'd0;
            if_id_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            pc          <= pc_d;
            if_id_instr <= instr_d;
            if_id_pc    <= ipc_d;
            if_id_valid <= valid_d;
            fetch_fault <= fault_d;
        end
    end
endmodule
